// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around one full_adder cell
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf_out.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf_out,
`endif
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_sum;
    logic             cell_carry;
    logic             last_bit;

    full_adder u_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers are written only on the final shift edge so they hold
    // the previous result through IDLE and SHIFT of the next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_out  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sum_sr <= {cell_sum, sum_sr[WIDTH-1:1]};
                    carry  <= cell_carry;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_out  <= {cell_sum, sum_sr[WIDTH-1:1]};
                        cout_out <= cell_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_out  <= carry ^ cell_carry;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
